// File: rtl/final_linear.sv
// Final fully-connected layer: streams weights from an external memory, accumulates
// one class at a time, then applies floor-shift, bias, saturation and a running argmax.
module final_linear #(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int FEATURES = 1280,
    parameter int CLASSES  = 10
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic signed [WIDTH-1:0]               data_in [0:FEATURES-1],
    input  logic                                  valid_in,
    output logic [$clog2(FEATURES*CLASSES)-1:0]   weight_addr,
    output logic                                  weight_rd,
    input  logic signed [WIDTH-1:0]               weight_data,
    input  logic signed [WIDTH-1:0]               bias [0:CLASSES-1],
    output logic signed [WIDTH-1:0]               logits [0:CLASSES-1],
    output logic [$clog2(CLASSES)-1:0]            class_idx,
    output logic                                  busy,
    output logic                                  valid_out
);
    localparam int AW    = $clog2(FEATURES*CLASSES);
    localparam int CW    = $clog2(CLASSES);
    localparam int FW    = (FEATURES > 1) ? $clog2(FEATURES) : 1;
    localparam int ACC_W = 2*WIDTH + $clog2(FEATURES);

    localparam logic signed [ACC_W:0] MAX_S = (ACC_W+1)'((64'sd1 <<< (WIDTH-1)) - 64'sd1);
    localparam logic signed [ACC_W:0] MIN_S = ~MAX_S;

    typedef enum logic [2:0] {IDLE, MAC, FLUSH, STORE, DONE} state_t;

    state_t                    state, state_nx;
    logic signed [WIDTH-1:0]   feat_buf [0:FEATURES-1];
    logic [FW-1:0]             feat, feat_d;
    logic [CW-1:0]             cls;
    logic                      rd_d;
    logic signed [ACC_W-1:0]   acc;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W:0]     sum_w;
    logic signed [WIDTH-1:0]   logit_nx;
    logic signed [WIDTH-1:0]   max_val;

    assign busy        = (state != IDLE);
    assign weight_rd   = en && (state == MAC);
    assign weight_addr = AW'(cls) * AW'(FEATURES) + AW'(feat);

    // feat_d tracks which buffered feature pairs with the data returning this cycle
    assign prod  = (2*WIDTH)'(feat_buf[feat_d]) * (2*WIDTH)'(weight_data);
    assign sum_w = (ACC_W+1)'(acc >>> FRAC) + (ACC_W+1)'(bias[cls]);

    always_comb begin
        logit_nx = sum_w[WIDTH-1:0];
        if (sum_w > MAX_S)
            logit_nx = {1'b0, {(WIDTH-1){1'b1}}};
        else if (sum_w < MIN_S)
            logit_nx = {1'b1, {(WIDTH-1){1'b0}}};
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (valid_in) state_nx = MAC;
            MAC:     if (feat == FW'(FEATURES-1)) state_nx = FLUSH;
            FLUSH:   state_nx = STORE;
            STORE:   state_nx = (cls == CW'(CLASSES-1)) ? DONE : MAC;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (en && state == IDLE && valid_in)
            feat_buf <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            feat      <= '0;
            feat_d    <= '0;
            cls       <= '0;
            rd_d      <= 1'b0;
            acc       <= '0;
            valid_out <= 1'b0;
            class_idx <= '0;
            max_val   <= '0;
            for (int c = 0; c < CLASSES; c++) logits[c] <= '0;
        end else if (en) begin
            state     <= state_nx;
            rd_d      <= weight_rd;
            feat_d    <= feat;
            valid_out <= (state == DONE);
            if (rd_d) acc <= acc + ACC_W'(prod);
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        acc  <= '0;
                        feat <= '0;
                        cls  <= '0;
                    end
                end
                MAC: begin
                    if (feat != FW'(FEATURES-1)) feat <= feat + 1'b1;
                end
                STORE: begin
                    logits[cls] <= logit_nx;
                    // strict compare keeps the lowest index on ties
                    if (cls == '0 || logit_nx > max_val) begin
                        max_val   <= logit_nx;
                        class_idx <= cls;
                    end
                    if (cls != CW'(CLASSES-1)) begin
                        cls  <= cls + 1'b1;
                        feat <= '0;
                        acc  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
